dm_unit: RTL
============

Name: dm_unit

Overview:
- Data-memory block of the M stage in the 5-stage MIPS pipeline; directly upstream of the M/W pipeline register.
- Performs byte, halfword and word stores with byte-lane masking, and sign/zero-extended loads.
- Its RD output is the value captured as RD_in into the W-stage register.
- Also flags misaligned and out-of-range accesses for the exception logic.

Parameters:
- AW, 12, word-address width; memory holds 2^AW 32-bit words (16 KiB by default).
- BASE, 32'h0000_0000, byte address of word 0.

Ports:
- clk  input  1  clock; all writes happen on the rising edge.
- reset  input  1  asynchronous active-low reset; clears every memory word to 0.
- WE  input  1  store request from the M-stage controller.
- MemOp  input  3  access type: 0 word, 1 half signed, 2 half unsigned, 3 byte signed, 4 byte unsigned; 5-7 reserved.
- Addr  input  32  byte address (ALU result).
- WD  input  32  store data from the forwarded rt value; low bits are used for sub-word stores.
- PC  input  32  PC of the M-stage instruction; used only by the trace feature.
- RD  output  32  load result after lane select and extension; combinational.
- AdErr  output  1  access is misaligned, or MemOp is reserved; combinational.
- OutRange  output  1  Addr is outside [BASE, BASE + 4*2^AW); combinational.

Behaviour:
- Storage: 2^AW x 32 array. Word index = (Addr-BASE)[AW+1:2]. Byte lane = Addr[1:0]; little-endian, lane 0 = bits 7:0.
- Reset:
  - While reset = 0, all words read as 0 and no write occurs, regardless of WE.
  - Reset is asynchronous; deasserting it mid-cycle causes no write until the next rising edge.
- Alignment:
  - Word access is misaligned if Addr[1:0] != 0.
  - Halfword access is misaligned if Addr[0] != 0.
  - Byte access is never misaligned.
  - Reserved MemOp sets AdErr = 1.
- Store on rising clk when reset = 1, WE = 1, AdErr = 0 and OutRange = 0:
  - Word: the whole word is replaced by WD.
  - Halfword: lanes {Addr[1],0} and {Addr[1],1} receive WD[15:0]; other lanes are unchanged.
  - Byte: lane Addr[1:0] receives WD[7:0]; other lanes are unchanged.
- A store with AdErr = 1 or OutRange = 1 is suppressed; the memory is unchanged.
- Load (always active, combinational from the current array contents):
  - Word: RD = word.
  - Halfword: selects the half at Addr[1]; MemOp 1 sign-extends bit 15, MemOp 2 zero-extends.
  - Byte: selects the lane at Addr[1:0]; MemOp 3 sign-extends bit 7, MemOp 4 zero-extends.
  - If AdErr = 1 or OutRange = 1, RD = 0.
- Read-during-write: in the cycle a store is presented, RD returns the pre-store contents. The new data is visible from the cycle after the edge.
- Flags:
  - AdErr and OutRange are independent and may both be 1.
  - Both flags are 0 while reset is asserted, unless the inputs themselves are illegal.
- No internal pipelining; zero-cycle read latency, one-edge write latency.

Optional Feature:
- Macro: DM_TRACE_EN.
- Defined: every performed store executes $display("@%h: *%h <= %h", PC, WordByteAddr, NewWord) at the write edge.
  - WordByteAddr is Addr with bits 1:0 cleared.
  - NewWord is the full merged 32-bit word after masking.
  - Suppressed stores print nothing.
- Undefined: no display code is compiled; behaviour is otherwise identical.

Test Plan:
- Reset clear: write 32'hDEADBEEF to 0x10, pulse reset low asynchronously mid-cycle, release -> LW 0x10 gives RD = 0; no write occurs while reset is low even with WE = 1.
- Word store/load: SW 32'h8000_00FF @0x20 -> next cycle LW 0x20 = 32'h800000FF, LB 0x20 = 32'hFFFFFFFF, LBU 0x20 = 32'h000000FF, LH 0x22 = 32'hFFFF8000, LHU 0x22 = 32'h00008000.
- Sub-word merge: SW 0 @0x30, then SB 32'hAB @0x31, then SH 32'h1234 @0x32 -> LW 0x30 = 32'h1234AB00.
- Misalign: SW @0x41 and SH @0x43 with WE = 1 -> AdErr = 1, RD = 0, word 0x40 unchanged; LB 0x43 -> AdErr = 0.
- Range: with AW = 12, SW @0x4000 -> OutRange = 1, store suppressed, RD = 0; SW @0x3FFC -> stored normally.
- Read-during-write: SW 32'h1 @0x50 over an old value of 32'h7 -> RD = 32'h7 in the store cycle and 32'h1 in the next cycle. With DM_TRACE_EN defined and PC = 32'h3000, exactly one line is printed: "@00003000: *00000050 <= 00000001".

Source files
------------

// File: rtl/dm_unit.sv
// ---------------------------------------------------------------------------
// dm_unit -- M-stage data memory for the 5-stage MIPS pipeline.
//
// Byte, halfword and word stores with byte-lane masking; sign/zero-extended
// loads. Reads are combinational from the current array contents, so a store
// cycle still reads the old word. Writes land on the rising clock edge.
// Misaligned or reserved accesses raise AdErr, addresses outside the mapped
// window raise OutRange, and either flag suppresses the store and zeroes RD.
//
// Optional feature macro: DM_TRACE_EN
//   When defined, every performed store prints
//   "@<PC>: *<word byte address> <= <merged word>" at the write edge.
//
// Parameters:
//   AW    word-address width (2^AW 32-bit words)
//   BASE  byte address of word 0
//
// Ports:
//   clk       clock, writes on rising edge
//   reset     asynchronous active-low reset, clears every word
//   WE        store request
//   MemOp     0 word, 1 half signed, 2 half unsigned, 3 byte signed,
//             4 byte unsigned, 5-7 reserved
//   Addr      byte address
//   WD        store data (low bits used for sub-word stores)
//   PC        PC of the M-stage instruction (trace only)
//   RD        load result (combinational)
//   AdErr     misaligned access or reserved MemOp (combinational)
//   OutRange  Addr outside [BASE, BASE + 4*2^AW) (combinational)
// ---------------------------------------------------------------------------
module dm_unit #(
  parameter int          AW   = 12,
  parameter logic [31:0] BASE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        WE,
  input  logic [2:0]  MemOp,
  input  logic [31:0] Addr,
  input  logic [31:0] WD,
  input  logic [31:0] PC,
  output logic [31:0] RD,
  output logic        AdErr,
  output logic        OutRange
);

  // Size of the mapped window in bytes; 33 bits so large AW cannot overflow.
  localparam logic [32:0] SPAN = 33'd4 << AW;

  logic [31:0]   mem_q [2**AW];
  logic [31:0]   offset;
  logic [AW-1:0] idx;
  logic [31:0]   cur_word;
  logic [31:0]   word_d;
  logic [15:0]   half_sel;
  logic [7:0]    byte_sel;
  logic          wr_en;

  // Address decode and access checks. An address below BASE wraps to a huge
  // offset, so a single compare covers both ends of the window.
  always_comb begin
    offset   = Addr - BASE;
    idx      = offset[AW+1:2];
    OutRange = ({1'b0, offset} >= SPAN);
    unique case (MemOp)
      3'd0:       AdErr = (Addr[1:0] != 2'b00);
      3'd1, 3'd2: AdErr = Addr[0];
      3'd3, 3'd4: AdErr = 1'b0;
      default:    AdErr = 1'b1;
    endcase
  end

  // Lane select and extension for loads.
  always_comb begin
    cur_word = mem_q[idx];
    half_sel = Addr[1] ? cur_word[31:16] : cur_word[15:0];
    unique case (Addr[1:0])
      2'd0:    byte_sel = cur_word[7:0];
      2'd1:    byte_sel = cur_word[15:8];
      2'd2:    byte_sel = cur_word[23:16];
      default: byte_sel = cur_word[31:24];
    endcase

    RD = 32'h0;
    if (!AdErr && !OutRange) begin
      unique case (MemOp)
        3'd0:    RD = cur_word;
        3'd1:    RD = {{16{half_sel[15]}}, half_sel};
        3'd2:    RD = {16'h0, half_sel};
        3'd3:    RD = {{24{byte_sel[7]}}, byte_sel};
        3'd4:    RD = {24'h0, byte_sel};
        default: RD = 32'h0;
      endcase
    end
  end

  // Merge store data into the current word; only the addressed lanes change.
  always_comb begin
    word_d = cur_word;
    unique case (MemOp)
      3'd0: word_d = WD;
      3'd1, 3'd2: begin
        if (Addr[1]) word_d[31:16] = WD[15:0];
        else         word_d[15:0]  = WD[15:0];
      end
      3'd3, 3'd4: begin
        unique case (Addr[1:0])
          2'd0:    word_d[7:0]   = WD[7:0];
          2'd1:    word_d[15:8]  = WD[7:0];
          2'd2:    word_d[23:16] = WD[7:0];
          default: word_d[31:24] = WD[7:0];
        endcase
      end
      default: word_d = cur_word;
    endcase
    wr_en = WE && !AdErr && !OutRange;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2**AW; i++) mem_q[i] <= 32'h0;
    end else if (wr_en) begin
      mem_q[idx] <= word_d;
    end
  end

`ifdef DM_TRACE_EN
  always_ff @(posedge clk) begin
    if (reset && wr_en)
      $display("@%h: *%h <= %h", PC, {Addr[31:2], 2'b00}, word_d);
  end
`else
  // PC only feeds the trace output.
  logic unused_pc;
  assign unused_pc = ^PC;
`endif

endmodule
